// File: rtl/vscale_dmem_bus_arbiter_if.sv
// HASTI (AHB-lite) signal bundle for N masters; master i's fields sit at [width*i +: width].
// The arbiter is the slave of a NUM_REQ-wide core bundle and the master of a 1-wide dmem bundle.
interface vscale_dmem_bus_arbiter_if #(
    parameter int N = 1
);
    logic [N*32-1:0] haddr;
    logic [N-1:0]    hwrite;
    logic [N*3-1:0]  hsize;
    logic [N*3-1:0]  hburst;
    logic [N-1:0]    hmastlock;
    logic [N*4-1:0]  hprot;
    logic [N*2-1:0]  htrans;
    logic [N*32-1:0] hwdata;
    logic [N*32-1:0] hrdata;
    logic [N-1:0]    hready;
    logic [N-1:0]    hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/vscale_dmem_bus_arbiter.sv
// Shares one HASTI dmem slave port among NUM_REQ vscale cores through 1-entry address slots.
// Round-robin grant by default; define ARB_EXT_SEL_EN to grant the core named by next_core.
module vscale_dmem_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    vscale_dmem_bus_arbiter_if.slave  core_bus,
    vscale_dmem_bus_arbiter_if.master dmem_bus,
    input  logic [IDX_W-1:0]          next_core
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_DATA
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        lock;
    } slot_t;

    state_t             state [NUM_REQ];
    slot_t              slot  [NUM_REQ];
    logic [IDX_W-1:0]   dp_idx;
    logic [IDX_W-1:0]   held_idx;
    logic               held_valid;
    logic [IDX_W-1:0]   grant;
    logic               issue_valid;
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] in_data;
    logic [NUM_REQ-1:0] capture;
    logic [NUM_REQ-1:0] core_ready;
    logic [NUM_REQ-1:0] core_resp;
`ifndef ARB_EXT_SEL_EN
    logic [IDX_W-1:0]   rr_ptr;
`endif

    // A core may hand over a new address whenever its own hready is high, including the
    // cycle its previous data phase completes.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i]       = (state[i] == ST_PEND);
            in_data[i]    = (state[i] == ST_DATA);
            core_ready[i] = (state[i] == ST_IDLE) | (in_data[i] & dmem_bus.hready[0]);
            core_resp[i]  = in_data[i] & dmem_bus.hresp[0];
            capture[i]    = core_ready[i] & core_bus.htrans[2*i+1];
        end
    end

    assign core_bus.hready = core_ready;
    assign core_bus.hresp  = core_resp;
    assign core_bus.hrdata = {NUM_REQ{dmem_bus.hrdata}};

    // A stalled address phase keeps its grant so the slave sees a stable address.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        issue_valid = 1'b0;
        grant       = '0;
        if (held_valid) begin
            issue_valid = 1'b1;
            grant       = held_idx;
        end else begin
`ifdef ARB_EXT_SEL_EN
            for (int i = 0; i < NUM_REQ; i++) begin
                if (int'(next_core) == i && pend[i]) begin
                    issue_valid = 1'b1;
                    grant       = IDX_W'(i);
                end
            end
`else
            for (int k = 1; k <= NUM_REQ; k++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!issue_valid && pend[i] && i == (int'(rr_ptr) + k) % NUM_REQ) begin
                        issue_valid = 1'b1;
                        grant       = IDX_W'(i);
                    end
                end
            end
`endif
        end
    end

    always_comb begin
        dmem_bus.haddr     = '0;
        dmem_bus.hwrite    = '0;
        dmem_bus.hsize     = '0;
        dmem_bus.hprot     = '0;
        dmem_bus.hmastlock = '0;
        dmem_bus.htrans    = HTRANS_IDLE;
        dmem_bus.hburst    = HBURST_SINGLE;
        dmem_bus.hwdata    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue_valid && grant == IDX_W'(i)) begin
                dmem_bus.haddr     = slot[i].addr;
                dmem_bus.hwrite    = slot[i].write;
                dmem_bus.hsize     = slot[i].size;
                dmem_bus.hprot     = slot[i].prot;
                dmem_bus.hmastlock = slot[i].lock;
                dmem_bus.htrans    = HTRANS_NONSEQ;
            end
            // Write data belongs to the core whose data phase is in flight, not to the grantee.
            if (in_data[i] && dp_idx == IDX_W'(i)) begin
                dmem_bus.hwdata = core_bus.hwdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                state[i] <= ST_IDLE;
            end
            dp_idx     <= '0;
            held_valid <= 1'b0;
            held_idx   <= '0;
`ifndef ARB_EXT_SEL_EN
            rr_ptr     <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            held_valid <= issue_valid & ~dmem_bus.hready[0];
            held_idx   <= grant;
            if (issue_valid && dmem_bus.hready[0]) begin
                dp_idx <= grant;
`ifndef ARB_EXT_SEL_EN
                rr_ptr <= grant;
`endif
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                case (state[i])
                    ST_IDLE: if (capture[i]) state[i] <= ST_PEND;
                    ST_PEND: begin
                        if (issue_valid && dmem_bus.hready[0] && grant == IDX_W'(i)) begin
                            state[i] <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (dmem_bus.hready[0]) begin
                            state[i] <= capture[i] ? ST_PEND : ST_IDLE;
                        end
                    end
                    default: state[i] <= ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: slots are storage, not control; no reset because a slot is read only after its capture.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (capture[i]) begin
                slot[i] <= '{addr:  core_bus.haddr[32*i +: 32],
                             write: core_bus.hwrite[i],
                             size:  core_bus.hsize[3*i +: 3],
                             prot:  core_bus.hprot[4*i +: 4],
                             lock:  core_bus.hmastlock[i]};
            end
        end
    end

    // Burst type is ignored (every slot goes out as SINGLE) and only htrans[1] distinguishes a request.
    logic unused_sigs;
`ifdef ARB_EXT_SEL_EN
    assign unused_sigs = ^{core_bus.hburst, core_bus.htrans};
`else
    assign unused_sigs = ^{core_bus.hburst, core_bus.htrans, next_core};
`endif

endmodule

// File: tb/tb_vscale_dmem_bus_arbiter.sv
// Self-checking bench for vscale_dmem_bus_arbiter: directed vector table, hand sequences,
// and randomized traffic against a request-level reference model.
module tb_vscale_dmem_bus_arbiter;
    localparam int NR = 4;
    localparam logic [31:0] HW_BASE = 32'hD000_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] next_core;

    vscale_dmem_bus_arbiter_if #(.N(NR)) core_bus();
    vscale_dmem_bus_arbiter_if #(.N(1))  dmem_bus();

    vscale_dmem_bus_arbiter #(.NUM_REQ(NR), .IDX_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .core_bus  (core_bus),
        .dmem_bus  (dmem_bus),
        .next_core (next_core)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_core(input int i, input logic [1:0] trans, input logic [31:0] addr,
                              input logic wr, input logic [2:0] size, input logic [3:0] prot,
                              input logic lock, input logic [31:0] wdata, input logic [2:0] burst);
        core_bus.htrans[2*i +: 2]  = trans;
        core_bus.haddr[32*i +: 32] = addr;
        core_bus.hwrite[i]         = wr;
        core_bus.hsize[3*i +: 3]   = size;
        core_bus.hprot[4*i +: 4]   = prot;
        core_bus.hmastlock[i]      = lock;
        core_bus.hwdata[32*i +: 32] = wdata;
        core_bus.hburst[3*i +: 3]  = burst;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NR; i++) drive_core(i, 2'b00, 32'h0, 1'b0, 3'b010, 4'h3, 1'b0, HW_BASE + 32'(i), 3'b000);
    endtask

    task automatic req_core(input int i, input logic [31:0] addr, input logic wr);
        drive_core(i, 2'b10, addr, wr, 3'b010, 4'h3, 1'b0, HW_BASE + 32'(i), 3'b000);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [31:0] base;
        logic [1:0]  nc;
        logic        hready;
        logic        hresp;
        logic [31:0] e_haddr;
        logic [1:0]  e_htrans;
        logic [31:0] e_hwdata;
        logic [3:0]  e_ready;
        logic [3:0]  e_resp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] wr,
                                input logic [31:0] base, input logic [1:0] nc, input logic hready,
                                input logic hresp, input logic [31:0] e_haddr, input logic [1:0] e_htrans,
                                input logic [31:0] e_hwdata, input logic [3:0] e_ready, input logic [3:0] e_resp);
        vec_t v;
        v = '{rst, req, wr, base, nc, hready, hresp, e_haddr, e_htrans, e_hwdata, e_ready, e_resp};
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        lock;
    } mreq_t;

    bit    m_has [NR];
    mreq_t m_req [NR];
    int    m_owner;
    int    m_stuck;
    int    m_last;

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_has[i] = 1'b0;
        m_owner = -1;
        m_stuck = -1;
        m_last  = NR - 1;
    endfunction

    function automatic int m_winner();
        if (m_stuck >= 0) return m_stuck;
`ifdef ARB_EXT_SEL_EN
        if (m_has[int'(next_core)]) return int'(next_core);
        return -1;
`else
        for (int k = 1; k <= NR; k++) begin
            if (m_has[(m_last + k) % NR]) return (m_last + k) % NR;
        end
        return -1;
`endif
    endfunction

    function automatic logic m_ready(input int i);
        if (m_has[i]) return 1'b0;
        if (m_owner == i) return dmem_bus.hready[0];
        return 1'b1;
    endfunction

    task automatic model_check(input int c);
        int          w;
        logic [3:0]  er, ep;
        logic [31:0] ea, ewd;
        logic [1:0]  et;
        logic        ew, el;
        logic [2:0]  es;
        logic [3:0]  eprot;
        w = m_winner();
        ea = 32'h0; et = 2'b00; ew = 1'b0; es = 3'b000; eprot = 4'h0; el = 1'b0; ewd = 32'h0;
        if (w >= 0) begin
            ea = m_req[w].addr; et = 2'b10; ew = m_req[w].wr;
            es = m_req[w].size; eprot = m_req[w].prot; el = m_req[w].lock;
        end
        if (m_owner >= 0) ewd = core_bus.hwdata[32*m_owner +: 32];
        for (int i = 0; i < NR; i++) begin
            er[i] = m_ready(i);
            ep[i] = (m_owner == i) ? dmem_bus.hresp[0] : 1'b0;
        end
        check($sformatf("cyc%0d haddr", c), dmem_bus.haddr, ea);
        check($sformatf("cyc%0d htrans", c), 32'(dmem_bus.htrans), 32'(et));
        check($sformatf("cyc%0d hwrite", c), 32'(dmem_bus.hwrite), 32'(ew));
        check($sformatf("cyc%0d hsize", c), 32'(dmem_bus.hsize), 32'(es));
        check($sformatf("cyc%0d hprot", c), 32'(dmem_bus.hprot), 32'(eprot));
        check($sformatf("cyc%0d hmastlock", c), 32'(dmem_bus.hmastlock), 32'(el));
        check($sformatf("cyc%0d hburst", c), 32'(dmem_bus.hburst), 32'h0);
        check($sformatf("cyc%0d hwdata", c), dmem_bus.hwdata, ewd);
        check($sformatf("cyc%0d core_hready", c), 32'(core_bus.hready), 32'(er));
        check($sformatf("cyc%0d core_hresp", c), 32'(core_bus.hresp), 32'(ep));
    endtask

    function automatic void model_step();
        int   w;
        logic hr;
        logic [3:0] take;
        if (reset) begin
            model_reset();
            return;
        end
        w  = m_winner();
        hr = dmem_bus.hready[0];
        for (int i = 0; i < NR; i++) take[i] = m_ready(i) & core_bus.htrans[2*i+1];
        if (w >= 0 && hr) begin
            m_owner  = w;
            m_has[w] = 1'b0;
            m_last   = w;
        end else if (hr) begin
            m_owner = -1;
        end
        m_stuck = (w >= 0 && !hr) ? w : -1;
        for (int i = 0; i < NR; i++) begin
            if (take[i]) begin
                m_has[i] = 1'b1;
                m_req[i] = '{core_bus.haddr[32*i +: 32], core_bus.hwrite[i], core_bus.hsize[3*i +: 3],
                             core_bus.hprot[4*i +: 4], core_bus.hmastlock[i]};
            end
        end
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b1;
        next_core = 2'd0;
        idle_all();
        dmem_bus.hready = 1'b1;
        dmem_bus.hresp  = 1'b0;
        dmem_bus.hrdata = 32'h0;
        repeat (2) @(posedge clk);

        //               rst  req     wr      base     nc    rdy  rsp   e_haddr   tr     e_hwdata      rdy     rsp
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h0,    2'b00, 32'h0,        4'hF, 4'h0)); // reset state
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 32'h100, 2'd0, 1, 0, 32'h0,    2'b00, 32'h0,        4'hF, 4'h0)); // core0 load
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h100,  2'b10, 32'h0,        4'hE, 4'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h0,    2'b00, 32'hD000_0000, 4'hF, 4'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h0,    2'b00, 32'h0,        4'hF, 4'h0));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h0,    2'b00, 32'h0,        4'hF, 4'h0)); // reset
        tbl.push_back(mk(0, 4'b0111, 4'b0111, 32'h10,  2'd0, 1, 0, 32'h0,    2'b00, 32'h0,        4'hF, 4'h0)); // 3 stores
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h10,   2'b10, 32'h0,        4'h8, 4'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd1, 1, 0, 32'h20,   2'b10, 32'hD000_0000, 4'h9, 4'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd2, 1, 0, 32'h30,   2'b10, 32'hD000_0001, 4'hB, 4'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h0,    2'b00, 32'hD000_0002, 4'hF, 4'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h0,    2'b00, 32'h0,        4'hF, 4'h0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 32'h40,  2'd1, 1, 0, 32'h0,    2'b00, 32'h0,        4'hF, 4'h0)); // core1 load
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 32'h40,  2'd1, 0, 0, 32'h50,   2'b10, 32'h0,        4'hD, 4'h0)); // stall 1
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 0, 0, 32'h50,   2'b10, 32'h0,        4'hC, 4'h0)); // stall 2
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 0, 0, 32'h50,   2'b10, 32'h0,        4'hC, 4'h0)); // stall 3
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h50,   2'b10, 32'h0,        4'hC, 4'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h40,   2'b10, 32'hD000_0001, 4'hE, 4'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h0,    2'b00, 32'hD000_0000, 4'hF, 4'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h0,    2'b00, 32'h0,        4'hF, 4'h0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 32'h80,  2'd2, 1, 0, 32'h0,    2'b00, 32'h0,        4'hF, 4'h0)); // core2 store
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd2, 1, 0, 32'hA0,   2'b10, 32'h0,        4'hB, 4'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 0, 1, 32'h0,    2'b00, 32'hD000_0002, 4'hB, 4'h4)); // ERROR 1
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 1, 32'h0,    2'b00, 32'hD000_0002, 4'hF, 4'h4)); // ERROR 2
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,   2'd0, 1, 0, 32'h0,    2'b00, 32'h0,        4'hF, 4'h0));

        for (int r = 0; r < tbl.size(); r++) begin
            tick();
            reset     = tbl[r].rst;
            next_core = tbl[r].nc;
            for (int i = 0; i < NR; i++) begin
                drive_core(i, tbl[r].req[i] ? 2'b10 : 2'b00, tbl[r].base + 32'(i*16), tbl[r].wr[i],
                           3'b010, 4'h3, 1'b0, HW_BASE + 32'(i), 3'b000);
            end
            dmem_bus.hready = tbl[r].hready;
            dmem_bus.hresp  = tbl[r].hresp;
            dmem_bus.hrdata = $urandom();
            sample();
            check($sformatf("row%0d haddr", r), dmem_bus.haddr, tbl[r].e_haddr);
            check($sformatf("row%0d htrans", r), 32'(dmem_bus.htrans), 32'(tbl[r].e_htrans));
            check($sformatf("row%0d hwdata", r), dmem_bus.hwdata, tbl[r].e_hwdata);
            check($sformatf("row%0d core_hready", r), 32'(core_bus.hready), 32'(tbl[r].e_ready));
            check($sformatf("row%0d core_hresp", r), 32'(core_bus.hresp), 32'(tbl[r].e_resp));
            for (int i = 0; i < NR; i++) begin
                check($sformatf("row%0d core%0d hrdata", r, i), core_bus.hrdata[32*i +: 32], dmem_bus.hrdata);
            end
        end

        // Reset while core3 is mid data phase with the slave stalling.
        tick(); reset = 1'b1; idle_all(); dmem_bus.hready = 1'b1; dmem_bus.hresp = 1'b0; sample();
        tick(); reset = 1'b0; next_core = 2'd3; req_core(3, 32'h230, 1'b1); sample();
        tick(); idle_all(); sample();
        check("rst3 addr issued", dmem_bus.haddr, 32'h230);
        tick(); reset = 1'b1; dmem_bus.hready = 1'b0; sample();
        check("rst3 core3 waiting", 32'(core_bus.hready), 32'h7);
        check("rst3 core3 hwdata", dmem_bus.hwdata, HW_BASE + 32'd3);
        tick(); reset = 1'b0; dmem_bus.hready = 1'b1; next_core = 2'd0;
        req_core(0, 32'h300, 1'b0); req_core(1, 32'h310, 1'b0); req_core(3, 32'h330, 1'b0);
        sample();
        check("rst3 htrans idle", 32'(dmem_bus.htrans), 32'h0);
        check("rst3 haddr zero", dmem_bus.haddr, 32'h0);
        check("rst3 all ready", 32'(core_bus.hready), 32'hF);
        check("rst3 all okay", 32'(core_bus.hresp), 32'h0);
        tick(); idle_all(); sample();
        check("rst3 core0 first", dmem_bus.haddr, 32'h300);
        tick(); next_core = 2'd1; sample();
        check("rst3 core1 second", dmem_bus.haddr, 32'h310);
        tick(); next_core = 2'd3; sample();
        check("rst3 core3 third", dmem_bus.haddr, 32'h330);
        tick(); sample();
        check("rst3 bus drained", 32'(dmem_bus.htrans), 32'h0);

`ifdef ARB_EXT_SEL_EN
        // External selection waits for next_core to name a pending core.
        tick(); reset = 1'b1; sample();
        tick(); reset = 1'b0; next_core = 2'd2; req_core(1, 32'h440, 1'b0); sample();
        tick(); idle_all(); sample();
        check("ext wrong sel idle", 32'(dmem_bus.htrans), 32'h0);
        tick(); sample();
        check("ext wrong sel idle again", 32'(dmem_bus.htrans), 32'h0);
        tick(); next_core = 2'd1; sample();
        check("ext core1 issued", dmem_bus.haddr, 32'h440);
        check("ext core1 nonseq", 32'(dmem_bus.htrans), 32'h2);
        tick(); sample();
`endif

        // Randomized traffic against the reference model.
        tick(); reset = 1'b1; idle_all(); dmem_bus.hready = 1'b1; dmem_bus.hresp = 1'b0; sample();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            tick();
            reset = ($urandom_range(0, 99) == 0);
            next_core = 2'($urandom_range(0, 3));
            for (int i = 0; i < NR; i++) begin
                drive_core(i, 2'($urandom_range(0, 3)), $urandom(), 1'($urandom_range(0, 1)),
                           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                           $urandom(), 3'($urandom_range(0, 7)));
            end
            dmem_bus.hready = ($urandom_range(0, 3) != 0);
            dmem_bus.hresp  = ($urandom_range(0, 15) == 0);
            dmem_bus.hrdata = $urandom();
            sample();
            model_check(c);
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
